// File: rtl/deserializer.sv
// Serial-to-parallel receiver: MSB-first frames sampled on the falling edge of the synchronized bit clock.
// Optional mid-frame gap timeout: define DESER_GAP_CHECK_EN.
module deserializer #(
   parameter int m           = 12,
   parameter int SYNC_STAGES = 2,
   parameter int GAP         = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ser_in,
   input  logic         sclk_in,
   output logic [m-1:0] par,
   output logic         valid,
   output logic         frame_err
);

   localparam int CW = $clog2(m + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(m - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE,
      ERR
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] ser_sync_q;
   logic                   sclk_s;
   logic                   sclk_prev_q;
   logic                   fall_q;
   logic                   bit_q;
   state_t                 state_q;
   logic [m-1:0]           shreg_q;
   logic [m-1:0]           par_q;
   logic [CW-1:0]          cnt_q;
   logic                   valid_q;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];

   // Equal-depth synchronizers keep bit clock and data aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         ser_sync_q  <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
         ser_sync_q  <= {ser_sync_q[SYNC_STAGES-2:0], ser_in};
      end
   end

   // Falling-edge strobe with the data bit captured alongside it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_prev_q <= 1'b0;
         fall_q      <= 1'b0;
         bit_q       <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_s;
         fall_q      <= sclk_prev_q & ~sclk_s;
         bit_q       <= ser_sync_q[SYNC_STAGES-1];
      end
   end

`ifdef DESER_GAP_CHECK_EN
   localparam int GW = $clog2(GAP + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
   logic [GW-1:0] gap_q;
   logic          err_q;
`endif

   // Frame FSM: collect m bits, publish the word, or drop a stalled frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         par_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
`ifdef DESER_GAP_CHECK_EN
         gap_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
`ifdef DESER_GAP_CHECK_EN
         err_q   <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
`ifdef DESER_GAP_CHECK_EN
               gap_q <= '0;
`endif
               if (fall_q) begin
                  shreg_q <= {shreg_q[m-2:0], bit_q};
                  cnt_q   <= CNT_ONE;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (fall_q) begin
                  shreg_q <= {shreg_q[m-2:0], bit_q};
                  cnt_q   <= cnt_q + CNT_ONE;
`ifdef DESER_GAP_CHECK_EN
                  gap_q   <= '0;
`endif
                  if (cnt_q == CNT_LAST) state_q <= DONE;
               end
`ifdef DESER_GAP_CHECK_EN
               else if (gap_q == GAP_LAST) begin
                  state_q <= ERR;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
`endif
            end
            DONE: begin
               par_q   <= shreg_q;
               valid_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            ERR: begin
`ifdef DESER_GAP_CHECK_EN
               err_q   <= 1'b1;
               gap_q   <= '0;
`endif
               shreg_q <= '0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign par   = par_q;
   assign valid = valid_q;
`ifdef DESER_GAP_CHECK_EN
   assign frame_err = err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer with a queue scoreboard on valid strobes.
// Gap-timeout scenario compiled only with DESER_GAP_CHECK_EN.
module tb_deserializer;

   localparam int M  = 12;
   localparam int SS = 2;

   logic         clk;
   logic         rst;
   logic         ser_in;
   logic         sclk_in;
   logic [M-1:0] par;
   logic         valid;
   logic         frame_err;

   int n_assert;
   int n_fail;
   int n_valid;
   int n_err;
   logic [M-1:0] exp_q[$];

   deserializer #(.m(M), .SYNC_STAGES(SS), .GAP(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .ser_in    (ser_in),
      .sclk_in   (sclk_in),
      .par       (par),
      .valid     (valid),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop and compare on every valid strobe.
   always @(negedge clk) begin
      if (!rst) begin
         check("valid_err_exclusive", {31'd0, valid & frame_err}, 32'd0);
         if (frame_err) n_err++;
         if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'd1, 32'd0);
            end else begin
               logic [M-1:0] e;
               e = exp_q.pop_front();
               check("par_word", {20'd0, par}, {20'd0, e});
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bit: 4 clk high, then low phase; optional latency probe on low phase.
   task automatic send_bit(input logic b, input int low, input bit probe);
      @(negedge clk);
      ser_in  = b;
      sclk_in = 1'b1;
      cycles(4);
      sclk_in = 1'b0;
      if (probe) begin
         for (int k = 0; k < low; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("latency_edge%0d", k), {31'd0, valid},
                  {31'd0, (k == SS + 2)});
         end
      end else begin
         cycles(low - 1);
      end
   endtask

   task automatic send_bits(input logic [M-1:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) send_bit(w[i], 4, 1'b0);
   endtask

   task automatic send_frame(input logic [M-1:0] w, input bit probe);
      exp_q.push_back(w);
      send_bits(w, M - 1, 1);
      send_bit(w[0], probe ? 8 : 4, probe);
   endtask

   initial begin
      int v0;
      n_assert = 0;
      n_fail   = 0;
      n_valid  = 0;
      n_err    = 0;
      rst      = 1'b1;
      ser_in   = 1'b0;
      sclk_in  = 1'b0;
      #1;
      check("rst_par", {20'd0, par}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      cycles(3);
      rst = 1'b0;
      cycles(5);

      send_frame(12'hA5C, 1'b1);
      cycles(4);
      check("single_count", n_valid, 1);
      check("single_par", {20'd0, par}, 32'hA5C);

      send_frame(12'hFFF, 1'b0);
      send_frame(12'h000, 1'b0);
      send_frame(12'h801, 1'b0);
      cycles(6);
      check("b2b_count", n_valid, 4);
      check("b2b_par", {20'd0, par}, 32'h801);

`ifdef DESER_GAP_CHECK_EN
      send_bits(12'h123, M - 1, M - 5);
      cycles(20);
      check("trunc_err_count", n_err, 1);
      check("trunc_no_valid", n_valid, 4);
      check("trunc_par_held", {20'd0, par}, 32'h801);
      send_frame(12'h123, 1'b0);
      cycles(6);
      check("after_err_par", {20'd0, par}, 32'h123);
`else
      exp_q.push_back(12'h123);
      send_bits(12'h123, M - 1, M - 5);
      cycles(50);
      check("pause_no_valid", n_valid, 4);
      send_bits(12'h123, M - 6, 0);
      cycles(6);
      check("pause_par", {20'd0, par}, 32'h123);
      check("pause_no_err", n_err, 0);
`endif

      v0 = n_valid;
      send_bits(12'hABC, M - 1, M - 6);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async_rst_par", {20'd0, par}, 32'd0);
      check("async_rst_valid", {31'd0, valid}, 32'd0);
      check("async_rst_err", {31'd0, frame_err}, 32'd0);
      cycles(3);
      rst = 1'b0;
      cycles(100);
      check("post_rst_quiet", n_valid, v0);
      send_frame(12'h3C3, 1'b0);
      cycles(6);
      check("rst_frame_count", n_valid, v0 + 1);
      check("rst_frame_par", {20'd0, par}, 32'h3C3);

      check("queue_empty", exp_q.size(), 0);
`ifdef DESER_GAP_CHECK_EN
      check("final_err_count", n_err, 1);
`else
      check("final_err_count", n_err, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
